ahb_fabric: RTL
===============

AHB_FABRIC -- requirements
Module: ahb_fabric

Interface
REQ-001 SHALL: DATA_WIDTH, 32, data bus width.
REQ-002 SHALL: ADDR_WIDTH, 32, address bus width.
REQ-003 SHALL: NUM_PORTS, 4, subordinate port count, legal range 1..16.
REQ-004 SHALL: BASEADDR, {NUM_PORTS{32'h0}}, packed NUM_PORTS*ADDR_WIDTH; port i base is slice i.
REQ-005 SHALL: SIZE, {NUM_PORTS{32'h1000}}, packed NUM_PORTS*ADDR_WIDTH; port i size in bytes, power of two, base aligned to size.
REQ-006 SHALL: TIMEOUT_CYCLES, 256, data-phase wait limit; used only with the macro in REQ-025.
REQ-007 SHALL: HCLK  in  1  single clock.
REQ-008 SHALL: HRESETn  in  1  asynchronous, active-low reset.
REQ-009 SHALL: S_HSEL, S_HADDR, S_HWRITE, S_HSIZE[2:0], S_HBURST[2:0], S_HPROT[3:0], S_HTRANS[1:0], S_HMASTLOCK, S_HWDATA  in  manager request.
REQ-010 SHALL: S_HREADY  out  1, S_HRESP  out  1, S_HRDATA  out  DATA_WIDTH  response to manager.
REQ-011 SHALL: M_HADDR, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HTRANS, M_HMASTLOCK, M_HWDATA  out  broadcast copies of S_* to all ports.
REQ-012 SHALL: M_HSEL  out  NUM_PORTS; M_HREADY  out  1 (HREADYIN to all ports).
REQ-013 SHALL: M_HREADYOUT  in  NUM_PORTS; M_HRESP  in  NUM_PORTS; M_HRDATA  in  NUM_PORTS*DATA_WIDTH.
REQ-014 SHALL: TIMEOUT  out  1  one-cycle pulse on data-phase timeout.

Function
REQ-015 SHALL: M_HSEL[i] = S_HSEL and BASEADDR_i <= S_HADDR < BASEADDR_i+SIZE_i, combinational; overlap resolved to lowest index only (one-hot).
REQ-016 SHALL: address phase accepted when S_HREADY=1; selected port index (or DEFAULT) registered into data-phase select dsel.
REQ-017 SHALL: S_HRDATA, S_HREADY, S_HRESP muxed from port dsel with zero added latency; M_HREADY = S_HREADY.
REQ-018 SHALL: dsel=IDLE (no S_HSEL, or HTRANS IDLE/BUSY to unmapped) -> S_HREADY=1, S_HRESP=0, S_HRDATA=0.
REQ-019 SHALL: NONSEQ/SEQ to unmapped address -> default-slave FSM IDLE->ERR1->ERR2->IDLE: ERR1 S_HREADY=0,S_HRESP=1; ERR2 S_HREADY=1,S_HRESP=1.
REQ-020 SHALL: new address phase presented during ERR2 is accepted normally (back-to-back error then valid transfer legal).
REQ-021 SHALL: dsel holds while S_HREADY=0; wait states from port pass through unmodified.
REQ-022 SHALL: port ERROR responses (two-cycle) pass through unmodified.

Reset
REQ-023 SHALL: on HRESETn=0: dsel=IDLE, FSM=IDLE, timeout counter=0, S_HREADY=1, S_HRESP=0, S_HRDATA=0, TIMEOUT=0; M_HSEL follows REQ-015 combinationally.
REQ-024 SHALL: reset asserted mid-transfer abandons it; first transfer after release decodes normally.

Configuration
REQ-025 SHALL: macro AHB_FABRIC_TIMEOUT_EN present -> counter increments each cycle a port data phase has M_HREADYOUT=0, clears on HREADY=1; at TIMEOUT_CYCLES fabric forces ERR1/ERR2 response to manager, pulses TIMEOUT, sets dsel=IDLE, ignores that port's stalled response.
REQ-026 SHALL: macro absent -> no counter, TIMEOUT tied 0, port stalls indefinitely.

Structure
REQ-027 SHALL: package ahb_fabric_pkg holds HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP OKAY/ERROR, default-slave FSM state enum, MAX_PORTS=16.
REQ-028 SHALL: sub-module ahb_default_slave implements REQ-019/REQ-025 error FSM; decode and mux stay in ahb_fabric.

Verification
REQ-029 SHALL: NUM_PORTS=4, map 0x0000_0000/0x8000, 0x2000_0000/0x2000, 0x4000_0000/0x1000, 0x4000_1000/0x1000; read 0x4000_1004, port3 returns 0xA5A5_0001 -> S_HRDATA=0xA5A5_0001, M_HSEL=4'b1000.
REQ-030 SHALL: NONSEQ read 0x3000_0000 -> ERR1 then ERR2 (HRESP=1 both, HREADY 0 then 1); following read 0x2000_0000 completes OKAY.
REQ-031 SHALL: write 0x2000_0010 with port1 inserting 3 wait states -> S_HREADY low exactly 3 cycles, dsel held, data 0xDEAD_BEEF seen by port1.
REQ-032 SHALL: overlapping map ports 0 and 1 both at 0x0/0x1000; access 0x0800 -> only M_HSEL[0]=1.
REQ-033 SHALL: AHB_FABRIC_TIMEOUT_EN, TIMEOUT_CYCLES=16, port2 holds HREADYOUT=0 -> after 16 cycles ERROR response, TIMEOUT pulse 1 cycle; next access to port0 OKAY.
REQ-034 SHALL: HRESETn asserted during port1 wait state -> outputs at reset values next edge; post-release read 0x0000_0004 returns port0 data.

Source files
------------

// File: rtl/ahb_fabric_pkg.sv
// Shared AHB encodings, default-slave state type and limits
// for the single-manager AHB decode/mux fabric.
package ahb_fabric_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_fabric_if.sv
// AHB bundle between the manager, the fabric and its subordinate ports.
// S_* faces the manager, M_* faces the subordinate ports.
interface ahb_fabric_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PORTS  = 4
);
    logic                            S_HSEL;
    logic [ADDR_WIDTH-1:0]           S_HADDR;
    logic                            S_HWRITE;
    logic [2:0]                      S_HSIZE;
    logic [2:0]                      S_HBURST;
    logic [3:0]                      S_HPROT;
    logic [1:0]                      S_HTRANS;
    logic                            S_HMASTLOCK;
    logic [DATA_WIDTH-1:0]           S_HWDATA;
    logic                            S_HREADY;
    logic                            S_HRESP;
    logic [DATA_WIDTH-1:0]           S_HRDATA;

    logic [NUM_PORTS-1:0]            M_HSEL;
    logic [ADDR_WIDTH-1:0]           M_HADDR;
    logic                            M_HWRITE;
    logic [2:0]                      M_HSIZE;
    logic [2:0]                      M_HBURST;
    logic [3:0]                      M_HPROT;
    logic [1:0]                      M_HTRANS;
    logic                            M_HMASTLOCK;
    logic [DATA_WIDTH-1:0]           M_HWDATA;
    logic                            M_HREADY;
    logic [NUM_PORTS-1:0]            M_HREADYOUT;
    logic [NUM_PORTS-1:0]            M_HRESP;
    logic [NUM_PORTS*DATA_WIDTH-1:0] M_HRDATA;

    modport slave (
        input  S_HSEL, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST,
        input  S_HPROT, S_HTRANS, S_HMASTLOCK, S_HWDATA,
        output S_HREADY, S_HRESP, S_HRDATA,
        output M_HSEL, M_HADDR, M_HWRITE, M_HSIZE, M_HBURST,
        output M_HPROT, M_HTRANS, M_HMASTLOCK, M_HWDATA, M_HREADY,
        input  M_HREADYOUT, M_HRESP, M_HRDATA
    );

    modport master (
        output S_HSEL, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST,
        output S_HPROT, S_HTRANS, S_HMASTLOCK, S_HWDATA,
        input  S_HREADY, S_HRESP, S_HRDATA,
        input  M_HSEL, M_HADDR, M_HWRITE, M_HSIZE, M_HBURST,
        input  M_HPROT, M_HTRANS, M_HMASTLOCK, M_HWDATA, M_HREADY,
        output M_HREADYOUT, M_HRESP, M_HRDATA
    );

endinterface

// File: rtl/ahb_fabric_ds.sv
// Default slave: two-cycle ERROR for unmapped transfers, plus the optional
// data-phase watchdog enabled by AHB_FABRIC_TIMEOUT_EN.
module ahb_default_slave
    import ahb_fabric_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_stall,
    output logic o_active,
    output logic o_hready,
    output logic o_fire,
    output logic o_timeout
);

    ds_state_e r_state;
    ds_state_e w_next;
    logic      w_fire;

`ifdef AHB_FABRIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Fires on the stalled cycle that completes the allowed wait budget.
    assign w_fire = i_stall && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_fire;
            if (!i_stall || w_fire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused;

    assign w_fire    = 1'b0;
    assign w_unused  = i_stall ^ (TIMEOUT_CYCLES == 0);
    assign o_timeout = 1'b0;
`endif

    assign o_fire = w_fire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_active = 1'b0;
        o_hready = 1'b1;
        unique case (r_state)
            DS_IDLE: begin
                if (i_start || w_fire) begin
                    w_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                o_active = 1'b1;
                o_hready = 1'b0;
                w_next   = DS_ERR2;
            end
            DS_ERR2: begin
                o_active = 1'b1;
                w_next   = i_start ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                w_next = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_fabric.sv
// Single-manager AHB decoder and response mux over NUM_PORTS subordinates.
// Optional data-phase watchdog: define AHB_FABRIC_TIMEOUT_EN.
module ahb_fabric
    import ahb_fabric_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_PORTS      = 4,
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASEADDR = {NUM_PORTS{32'h0}},
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] SIZE     = {NUM_PORTS{32'h1000}},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_fabric_if.slave   bus,
    output logic          TIMEOUT
);

    logic [NUM_PORTS-1:0]  w_hit;
    logic [NUM_PORTS-1:0]  w_sel;
    logic [NUM_PORTS-1:0]  r_dsel;
    logic                  w_start;
    logic                  w_stall;
    logic                  w_fire;
    logic                  w_timeout;
    logic                  w_ds_active;
    logic                  w_ds_hready;
    logic                  w_p_ready;
    logic                  w_p_resp;
    logic [DATA_WIDTH-1:0] w_p_rdata;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Base is aligned to a power-of-two size, so a mask compare is exact.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dec
        localparam logic [ADDR_WIDTH-1:0] BASE =
            BASEADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] MASK =
            ~(SIZE[g*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(1));
        assign w_hit[g] = bus.S_HSEL &&
            ((bus.S_HADDR & MASK) == BASE);
    end

    // Keep only the lowest-index hit.
    assign w_sel = w_hit & (~w_hit + NUM_PORTS'(1));

    assign w_start = bus.S_HSEL && (w_sel == '0) &&
        htrans_active(bus.S_HTRANS) && w_hready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= '0;
        end else if (w_fire) begin
            r_dsel <= '0;
        end else if (w_hready) begin
            r_dsel <= w_sel;
        end
    end

    always_comb begin
        w_p_ready = 1'b1;
        w_p_resp  = HRESP_OKAY;
        w_p_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_dsel[i]) begin
                w_p_ready = bus.M_HREADYOUT[i];
                w_p_resp  = bus.M_HRESP[i];
                w_p_rdata = bus.M_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_stall = (|r_dsel) && !w_p_ready;

    ahb_default_slave #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ds (
        .i_clk     (HCLK),
        .i_rst_n   (HRESETn),
        .i_start   (w_start),
        .i_stall   (w_stall),
        .o_active  (w_ds_active),
        .o_hready  (w_ds_hready),
        .o_fire    (w_fire),
        .o_timeout (w_timeout)
    );

    always_comb begin
        if (w_ds_active) begin
            w_hready = w_ds_hready;
            w_hresp  = HRESP_ERROR;
            w_rdata  = '0;
        end else begin
            w_hready = w_p_ready;
            w_hresp  = w_p_resp;
            w_rdata  = w_p_rdata;
        end
    end

    assign bus.S_HREADY    = w_hready;
    assign bus.S_HRESP     = w_hresp;
    assign bus.S_HRDATA    = w_rdata;
    assign bus.M_HREADY    = w_hready;
    assign bus.M_HSEL      = w_sel;
    assign bus.M_HADDR     = bus.S_HADDR;
    assign bus.M_HWRITE    = bus.S_HWRITE;
    assign bus.M_HSIZE     = bus.S_HSIZE;
    assign bus.M_HBURST    = bus.S_HBURST;
    assign bus.M_HPROT     = bus.S_HPROT;
    assign bus.M_HTRANS    = bus.S_HTRANS;
    assign bus.M_HMASTLOCK = bus.S_HMASTLOCK;
    assign bus.M_HWDATA    = bus.S_HWDATA;
    assign TIMEOUT         = w_timeout;

endmodule
